// File: rtl/l2_arbiter_rr_if.sv
// Bus bundle between the L1 miss ports, the round-robin arbiter and the L2 port.
// The arbiter uses the slave view; the surrounding L1/L2 environment uses the master view.
interface l2_arbiter_rr_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LINE_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_resp;
  logic [LINE_W-1:0]         req_rdata;

  logic                      mem_read;
  logic                      mem_write;
  logic [ADDR_W-1:0]         mem_addr;
  logic [LINE_W-1:0]         mem_wdata;
  logic                      mem_resp;
  logic [LINE_W-1:0]         mem_rdata;

  logic [ID_W-1:0]           grant_id;
  logic                      busy;

  modport slave (
    input  req_read, req_write, req_addr, req_wdata, mem_resp, mem_rdata,
    output req_resp, req_rdata, mem_read, mem_write, mem_addr, mem_wdata, grant_id, busy
  );

  modport master (
    output req_read, req_write, req_addr, req_wdata, mem_resp, mem_rdata,
    input  req_resp, req_rdata, mem_read, mem_write, mem_addr, mem_wdata, grant_id, busy
  );
endinterface

// File: rtl/l2_arbiter_rr.sv
// Round-robin arbiter from NUM_REQ L1 miss ports onto one L2 port; the grant is
// locked from request capture until the L2 completion pulse.
module l2_arbiter_rr #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  l2_arbiter_rr_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     grant_id;
  logic                mem_read;
  logic                mem_write;
  logic                busy;
  logic [ADDR_W-1:0]   mem_addr;
  logic [LINE_W-1:0]   mem_wdata;

  logic [NUM_REQ-1:0]  active;
  logic [NUM_REQ-1:0]  rotated;
  logic                any_active;
  logic [ID_W-1:0]     pick_id;
  logic                pick_read;
  logic                pick_write;
  logic [ADDR_W-1:0]   pick_addr;
  logic [LINE_W-1:0]   pick_wdata;

  assign active = bus.req_read | bus.req_write;

  // Rotate the active vector so bit 0 is the port at rr_ptr; the lowest set bit wins.
  assign rotated = NUM_REQ'({active, active} >> rr_ptr);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    int first_k;
    int sel;
    first_k    = 0;
    any_active = |rotated;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) first_k = k;
    end
    sel = int'(rr_ptr) + first_k;
    if (sel >= NUM_REQ) sel = sel - NUM_REQ;
    pick_id    = ID_W'(sel);
    pick_read  = 1'b0;
    pick_write = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i == sel) begin
        pick_read  = bus.req_read[i];
        pick_write = bus.req_write[i];
        pick_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        pick_wdata = bus.req_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_active) begin
            mem_addr  <= pick_addr;
            mem_wdata <= pick_wdata;
            // A port raising both read and write is treated as a write.
            mem_write <= pick_write;
            mem_read  <= pick_read & ~pick_write;
            grant_id  <= pick_id;
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
            rr_ptr    <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is forwarded in the same cycle the L2 reports it.
  assign bus.req_resp  = (state == BUSY && bus.mem_resp) ? (NUM_REQ'(1) << grant_id) : '0;
  assign bus.req_rdata = bus.mem_rdata;

  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.grant_id  = grant_id;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_l2_arbiter_rr.sv
// Self-checking bench for l2_arbiter_rr: transaction-level reference model, per-cycle
// compare on the falling edge, directed scenarios and a randomized soak.
module tb_l2_arbiter_rr;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  l2_arbiter_rr_if #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW)) bus ();

  l2_arbiter_rr #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: one outstanding transaction, served from the rotating pointer.
  bit            m_busy, m_rd, m_wr;
  int            m_port, m_ptr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  int            grant_log[$];

  always @(posedge clk or negedge rst_n) begin : ref_model
    int  p;
    bit  found;
    if (!rst_n) begin
      m_busy <= 0; m_rd <= 0; m_wr <= 0; m_port <= 0; m_ptr <= 0;
      m_addr <= '0; m_wdata <= '0;
    end else if (m_busy) begin
      if (bus.mem_resp) begin
        m_busy <= 0; m_rd <= 0; m_wr <= 0;
        m_ptr  <= (m_port + 1) % N;
      end
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (!found && (bus.req_read[p] || bus.req_write[p])) begin
          found = 1;
          m_busy  <= 1;
          m_port  <= p;
          m_addr  <= bus.req_addr[p*AW +: AW];
          m_wdata <= bus.req_wdata[p*LW +: LW];
          m_wr    <= bus.req_write[p];
          m_rd    <= bus.req_read[p] && !bus.req_write[p];
          grant_log.push_back(p);
        end
      end
    end
  end

  bit cmp_en = 0;
  bit prev_done = 0;

  always @(negedge clk) begin : compare
    logic [N-1:0] exp_resp;
    if (cmp_en) begin
      exp_resp = '0;
      if (m_busy && bus.mem_resp === 1'b1) exp_resp[m_port] = 1'b1;
      check("mem_read",  LW'(bus.mem_read),  LW'(m_rd));
      check("mem_write", LW'(bus.mem_write), LW'(m_wr));
      check("mem_addr",  LW'(bus.mem_addr),  LW'(m_addr));
      check("mem_wdata", bus.mem_wdata,      m_wdata);
      check("grant_id",  LW'(bus.grant_id),  LW'(m_port));
      check("busy",      LW'(bus.busy),      LW'(m_busy));
      check("req_resp",  LW'(bus.req_resp),  LW'(exp_resp));
      check("req_rdata", bus.req_rdata,      bus.mem_rdata);
      if (prev_done) check("idle_gap", LW'(bus.mem_read | bus.mem_write), '0);
      prev_done <= m_busy && bus.mem_resp === 1'b1;
    end
  end

  // Environment: requesters hold until served, L2 answers after a random latency.
  bit auto_req [N];
  int lat_cnt   = -1;
  int resp_port = -1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [LW-1:0] d);
    bus.req_read[p]              = rd;
    bus.req_write[p]             = wr;
    bus.req_addr[p*AW +: AW]     = a;
    bus.req_wdata[p*LW +: LW]    = d;
  endtask

  task automatic new_req(input int p);
    int kind;
    kind = $urandom_range(0, 2);
    set_req(p, kind != 1, kind != 0, $urandom, rand_line());
  endtask

  task automatic env_step(input int new_pct, input int spur_pct);
    bit cleared [N];
    foreach (cleared[i]) cleared[i] = 0;
    if (bus.mem_resp) begin
      bus.mem_resp = 0;
      if (resp_port >= 0) begin
        bus.req_read[resp_port]  = 0;
        bus.req_write[resp_port] = 0;
        cleared[resp_port] = 1;
      end
      resp_port = -1;
    end else if (m_busy) begin
      if (lat_cnt < 0) lat_cnt = $urandom_range(0, 3);
      if (lat_cnt == 0) begin
        bus.mem_resp  = 1;
        bus.mem_rdata = rand_line();
        resp_port     = m_port;
        lat_cnt       = -1;
      end else begin
        lat_cnt--;
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.req_addr[m_port*AW +: AW]  = $urandom;
        bus.req_wdata[m_port*LW +: LW] = rand_line();
      end
    end else if ($urandom_range(0, 99) < spur_pct) begin
      bus.mem_resp  = 1;
      bus.mem_rdata = rand_line();
      resp_port     = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (!cleared[i] && !(bus.req_read[i] || bus.req_write[i]) &&
          (auto_req[i] || $urandom_range(0, 99) < new_pct))
        new_req(i);
    end
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (c < budget && (m_busy || bus.mem_resp || (|(bus.req_read | bus.req_write)))) begin
      tick();
      env_step(0, 0);
      c++;
    end
    check("drain_idle", LW'(m_busy || (|(bus.req_read | bus.req_write))), '0);
  endtask

  task automatic run_grants(input int base, input int n, input int budget);
    int c;
    c = 0;
    while (c < budget && grant_log.size() < base + n) begin
      tick();
      env_step(0, 0);
      c++;
    end
    check("grant_count", LW'(grant_log.size() >= base + n), LW'(1));
    foreach (auto_req[i]) auto_req[i] = 0;
    drain(200);
  endtask

  task automatic do_reset();
    bus.req_read  = '0;
    bus.req_write = '0;
    bus.mem_resp  = 0;
    lat_cnt       = -1;
    resp_port     = -1;
    foreach (auto_req[i]) auto_req[i] = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic check_order(input string name, input int base, input int exp_seq [4]);
    int got;
    for (int i = 0; i < 4; i++) begin
      got = (base + i < grant_log.size()) ? grant_log[base + i] : -1;
      check(name, LW'(got), LW'(exp_seq[i]));
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    int ord2 [4];
    int ord3 [4];
    logic [LW-1:0] a5_line;
    logic [LW-1:0] dead_line;
    ord2      = '{0, 1, 0, 1};
    ord3      = '{0, 1, 2, 0};
    a5_line   = {8{32'hA5A5_A5A5}};
    dead_line = {8{32'hDEAD_BEEF}};

    rst_n = 1;
    bus.req_read = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_resp = 1;  bus.mem_rdata = '0;
    #1 rst_n = 0;
    #1;
    cmp_en = 1;
    check("rst_mem_read",  LW'(bus.mem_read),  '0);
    check("rst_mem_write", LW'(bus.mem_write), '0);
    check("rst_mem_addr",  LW'(bus.mem_addr),  '0);
    check("rst_mem_wdata", bus.mem_wdata,      '0);
    check("rst_grant_id",  LW'(bus.grant_id),  '0);
    check("rst_busy",      LW'(bus.busy),      '0);
    check("rst_req_resp",  LW'(bus.req_resp),  '0);
    bus.mem_resp = 0;
    tick();
    tick();
    rst_n = 1;

    // Single read from the Icache port.
    set_req(0, 1, 0, 32'h0000_1000, '0);
    tick();
    check("t1_mem_read", LW'(bus.mem_read), LW'(1));
    check("t1_mem_addr", LW'(bus.mem_addr), LW'(32'h1000));
    check("t1_busy",     LW'(bus.busy),     LW'(1));
    bus.mem_rdata = a5_line;
    bus.mem_resp  = 1;
    #1;
    check("t1_req_resp",  LW'(bus.req_resp), LW'(3'b001));
    check("t1_req_rdata", bus.req_rdata,     a5_line);
    tick();
    bus.mem_resp = 0;
    bus.req_read[0] = 0;
    check("t1_strobe_drop", LW'(bus.mem_read), '0);
    check("t1_busy_drop",   LW'(bus.busy),     '0);

    // Two ports competing continuously alternate.
    do_reset();
    base = grant_log.size();
    auto_req[0] = 1; auto_req[1] = 1;
    run_grants(base, 4, 300);
    check_order("t2_order", base, ord2);

    // Three ports competing: order wraps through the non-power-of-two count.
    do_reset();
    base = grant_log.size();
    foreach (auto_req[i]) auto_req[i] = 1;
    run_grants(base, 4, 300);
    check_order("t3_order", base, ord3);

    // Write with simultaneous read; later input changes on the granted port are ignored.
    set_req(1, 1, 1, 32'h40, dead_line);
    tick();
    check("t4_mem_write", LW'(bus.mem_write), LW'(1));
    check("t4_mem_read",  LW'(bus.mem_read),  '0);
    check("t4_mem_wdata", bus.mem_wdata,      dead_line);
    check("t4_grant_id",  LW'(bus.grant_id),  LW'(1));
    set_req(1, 1, 1, 32'h80, rand_line());
    tick();
    tick();
    check("t5_addr_held",  LW'(bus.mem_addr), LW'(32'h40));
    check("t5_wdata_held", bus.mem_wdata,     dead_line);
    check("t5_write_held", LW'(bus.mem_write), LW'(1));
    bus.mem_resp = 1;
    #1;
    check("t4_req_resp", LW'(bus.req_resp), LW'(3'b010));
    tick();
    bus.mem_resp = 0;
    bus.req_read[1] = 0; bus.req_write[1] = 0;
    bus.mem_resp = 1;
    #1;
    check("t5_idle_resp", LW'(bus.req_resp), '0);
    tick();
    bus.mem_resp = 0;
    check("t5_still_idle", LW'(bus.busy), '0);

    // Asynchronous reset in the middle of a transaction.
    set_req(2, 1, 0, 32'h200, '0);
    tick();
    check("t6_busy_before", LW'(bus.busy), LW'(1));
    #2 rst_n = 0;
    #1;
    check("t6_async_read", LW'(bus.mem_read), '0);
    check("t6_async_busy", LW'(bus.busy),     '0);
    bus.req_read = '0;
    tick();
    tick();
    rst_n = 1;
    bus.mem_resp = 1;
    #1;
    check("t6_post_rst_resp", LW'(bus.req_resp), '0);
    tick();
    bus.mem_resp = 0;
    set_req(1, 1, 0, 32'h300, '0);
    set_req(2, 1, 0, 32'h400, '0);
    tick();
    check("t6_grant_from_0", LW'(bus.grant_id), LW'(1));
    check("t6_addr",         LW'(bus.mem_addr), LW'(32'h300));
    drain(200);

    // Randomized soak with spurious L2 pulses in idle.
    for (int c = 0; c < 4000; c++) begin
      tick();
      env_step(25, 3);
    end
    drain(300);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
